burst_data_memory: RTL and testbench
====================================

Name: burst_data_memory

Overview:
- Parametrised data memory for the CPU load/store path. Successor to the single-word, combinational load/store memory.
- Adds a clocked single-port array, byte-lane write enables, and multi-beat bursts (LDM/STM-style) via a request handshake.
- A base word address plus a beat count replaces the external per-beat index.
- Sits between the execute stage's load/store unit and the writeback path.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
DEPTH, 16, number of words; power of 2, at least 2.
MAX_BEATS, 16, maximum beats per burst; power of 2, at most DEPTH.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  1  burst request present.
req_ready  output  1  block can accept a request; high only in IDLE.
req_store  input  1  1 = store burst, 0 = load burst.
req_addr  input  clog2(DEPTH)  base word address.
req_count  input  clog2(MAX_BEATS)  number of beats minus 1.
wr_valid  input  1  store beat data present.
wr_ready  output  1  store beat accepted; high only in STORE.
wr_data  input  DATA_W  store beat data.
wr_be  input  DATA_W/8  byte-lane write enables for the store beat.
rd_valid  output  1  load beat data valid.
rd_data  output  DATA_W  load beat data.
rd_last  output  1  marks the final load beat.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; beat counter and base are cleared.
  - Outputs after reset: req_ready=1, wr_ready=0, rd_valid=0, rd_data=0, rd_last=0, busy=0.
  - Array contents are not reset.
- FSM states are IDLE, LOAD and STORE.
- IDLE:
  - A request is accepted when req_valid & req_ready at edge T.
  - On acceptance, latch base=req_addr, last=req_count and clear beat k=0.
  - Go to STORE if req_store, else LOAD.
- LOAD:
  - One array read per cycle at index (base+k) mod DEPTH.
  - The read is registered: beat k appears on rd_data with rd_valid=1 in the cycle after edge T+1+k.
  - There is no read-side backpressure; the consumer must accept every beat.
  - rd_last=1 together with the beat where k=last.
  - After the last beat is issued, the FSM returns to IDLE, so req_ready=1 in the same cycle that rd_last is shown.
  - Burst latency is 1 cycle to the first data, then 1 beat per cycle.
- STORE:
  - wr_ready=1 throughout STORE.
  - Each edge with wr_valid=1 writes wr_data to index (base+k), updating only the byte lanes whose wr_be bit is set, then increments k.
  - wr_valid=0 stalls the burst with no write and no k change, indefinitely.
  - The beat with k=last returns the FSM to IDLE on the same edge.
  - wr_be=0 consumes a beat without modifying memory.
- Address arithmetic:
  - Computed in clog2(DEPTH) bits, so it wraps modulo DEPTH; e.g. base=14 with 4 beats gives 14, 15, 0, 1.
- rd_data holds its last value when rd_valid=0; it is not cleared.
- Ordering: only one burst is active at a time. A load accepted right after a store completes returns the new data.
- Requests presented while busy are ignored, because req_ready=0; the requester must hold req_valid.
- wr_valid outside STORE is ignored and must cause no write.
- Reset mid-burst:
  - The burst is abandoned and rd_valid drops immediately.
  - Store beats already written persist; no rollback.
- req_count=0 makes a single-beat transfer.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, LOAD, STORE};
  - localparams ADDR_W=$clog2(DEPTH), CNT_W=$clog2(MAX_BEATS), BE_W=DATA_W/8.
- Sub-module mem_array:
  - single-port synchronous RAM, parametrised by DATA_W and DEPTH;
  - inputs en, we, be, addr, wdata; registered rdata;
  - no reset on storage.
- The top-level block holds the FSM, beat counter, address adder and handshake logic.

Test Plan:
- Reset check:
  - Drive rst low mid-simulation.
  - Required: req_ready=1, busy=0, rd_valid=0, rd_data=0 immediately; no clock is needed.
- Store then load:
  - Store burst with addr=2, count=3, data 0x11, 0x22, 0x33, 0x44 (full be).
  - Then load with addr=2, count=3.
  - Required: rd_valid for 4 consecutive cycles returning 0x11..0x44, with rd_last only on 0x44.
- Wrap-around:
  - Store with addr=14, count=3, data 0xA..0xD.
  - Load single beats at addr 0 and addr 15.
  - Required: 0xC and 0xB respectively.
- Byte enables:
  - Write 0xFFFFFFFF at addr 5, then write 0x12345678 with be=4'b0101.
  - Required: load of addr 5 returns 0xFF34FF78.
- Stall and blocking:
  - During a 2-beat store, hold wr_valid=0 for 3 cycles between beats.
  - Required: wr_ready stays 1, busy=1, req_ready=0, and only 2 writes occur.
  - A req_valid asserted during the burst is accepted only once the FSM is back in IDLE.
- Reset mid-burst:
  - Assert rst after 2 of 4 store beats (0x1, 0x2 to addr 8).
  - Required after release: load of addr 8 and 9 returns 0x1, 0x2; addr 10 is unchanged.

Source files
------------

// File: rtl/burst_data_memory_pkg.sv
// Shared types and default sizing for the burst data memory.
// Each instance derives its address and beat-count widths from its own parameters.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_MAX_BEATS = 16;
  localparam int ADDR_W        = $clog2(DEF_DEPTH);
  localparam int CNT_W         = $clog2(DEF_MAX_BEATS);
  localparam int BE_W          = DEF_DATA_W / 8;

endpackage

// File: rtl/burst_data_memory_mem_array.sv
// Single-port synchronous RAM with byte-lane write enables and a registered read.
// Storage has no reset. rdata keeps its value on cycles that do not read.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < LANES; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/burst_data_memory.sv
// Burst load/store data memory: request handshake, beat counter and wrapping address.
// Loads return one beat per cycle. Stores advance one beat per accepted wr_valid.
module burst_data_memory
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_store,
  input  logic [$clog2(DEPTH)-1:0]      req_addr,
  input  logic [$clog2(MAX_BEATS)-1:0]  req_count,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W/8-1:0]           wr_be,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_last,
  output logic                          busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_BEATS);

  state_t          state_reg, state_next;
  logic [AW-1:0]   base_reg, base_next;
  logic [CW-1:0]   last_reg, last_next;
  logic [CW-1:0]   k_reg, k_next;
  logic            rd_valid_reg, rd_valid_next;
  logic            rd_last_reg, rd_last_next;
  logic            seen_reg, seen_next;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  // Address arithmetic is done in AW bits, so bursts wrap modulo DEPTH.
  assign mem_addr = base_reg + AW'(k_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      last_reg     <= '0;
      k_reg        <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      seen_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      base_reg     <= base_next;
      last_reg     <= last_next;
      k_reg        <= k_next;
      rd_valid_reg <= rd_valid_next;
      rd_last_reg  <= rd_last_next;
      seen_reg     <= seen_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    base_next     = base_reg;
    last_next     = last_reg;
    k_next        = k_reg;
    rd_valid_next = 1'b0;
    rd_last_next  = 1'b0;
    seen_next     = seen_reg;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          base_next  = req_addr;
          last_next  = req_count;
          k_next     = '0;
          state_next = req_store ? STORE : LOAD;
        end
      end
      LOAD: begin
        mem_en        = 1'b1;
        rd_valid_next = 1'b1;
        rd_last_next  = (k_reg == last_reg);
        seen_next     = 1'b1;
        k_next        = k_reg + 1'b1;
        if (k_reg == last_reg) state_next = IDLE;
      end
      STORE: begin
        if (wr_valid) begin
          mem_en = 1'b1;
          mem_we = 1'b1;
          k_next = k_reg + 1'b1;
          if (k_reg == last_reg) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .be   (wr_be),
    .addr (mem_addr),
    .wdata(wr_data),
    .rdata(mem_rdata)
  );

  assign req_ready = (state_reg == IDLE);
  assign wr_ready  = (state_reg == STORE);
  assign busy      = (state_reg != IDLE);
  assign rd_valid  = rd_valid_reg;
  assign rd_last   = rd_last_reg;
  // The unreset RAM output register is masked until a load has run since reset.
  assign rd_data   = seen_reg ? mem_rdata : '0;

endmodule

// File: tb/tb_burst_data_memory.sv
// Directed self-checking bench for burst_data_memory.
// Every expected value is hand-computed.
module tb_burst_data_memory;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [3:0]  req_addr;
  logic [3:0]  req_count;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;

  logic [31:0] wdat  [16];
  logic [3:0]  wbe   [16];
  logic [31:0] exp_d [16];
  int tests = 0;
  int fails = 0;

  burst_data_memory #(.DATA_W(32), .DEPTH(16), .MAX_BEATS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_store(req_store),
    .req_addr (req_addr),
    .req_count(req_count),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_wr_ready"},  32'(wr_ready),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, "_rd_last"},   32'(rd_last),   32'd0);
    check({tag, "_rd_data"},   rd_data,        32'd0);
  endtask

  task automatic store_burst(input logic [3:0] a, input logic [3:0] c);
    req_valid = 1'b1; req_store = 1'b1; req_addr = a; req_count = c;
    step();
    req_valid = 1'b0; req_store = 1'b0;
    for (int i = 0; i <= int'(c); i++) begin
      check("st_wr_ready", 32'(wr_ready), 32'd1);
      check("st_busy", 32'(busy), 32'd1);
      check("st_req_ready", 32'(req_ready), 32'd0);
      wr_valid = 1'b1; wr_data = wdat[i]; wr_be = wbe[i];
      step();
    end
    wr_valid = 1'b0;
    check("st_done_req_ready", 32'(req_ready), 32'd1);
    $display("[TB] store addr=%0d beats=%0d", a, int'(c) + 1);
  endtask

  task automatic collect(input logic [3:0] c, input string tag);
    for (int i = 0; i <= int'(c); i++) begin
      step();
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_rd_data"}, rd_data, exp_d[i]);
      check({tag, "_rd_last"}, 32'(rd_last), (i == int'(c)) ? 32'd1 : 32'd0);
    end
    check({tag, "_ready_with_last"}, 32'(req_ready), 32'd1);
    step();
    check({tag, "_rd_valid_after"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data_hold"}, rd_data, exp_d[c]);
    $display("[TB] load %s beats=%0d", tag, int'(c) + 1);
  endtask

  task automatic load_burst(input logic [3:0] a, input logic [3:0] c, input string tag);
    req_valid = 1'b1; req_store = 1'b0; req_addr = a; req_count = c;
    step();
    req_valid = 1'b0;
    collect(c, tag);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_count = '0;
    wr_valid = 1'b0; wr_data = '0; wr_be = '0;
    step(); step();
    check_idle_reset("por");
    rst = 1'b1;
    step();

    // Store then load, addr 2, 4 beats
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'h11 * (i + 1); wbe[i] = 4'hF; exp_d[i] = 32'h11 * (i + 1);
    end
    store_burst(4'd2, 4'd3);
    load_burst(4'd2, 4'd3, "sl");

    // Wrap-around from 14
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 32'hA + i; wbe[i] = 4'hF;
    end
    store_burst(4'd14, 4'd3);
    exp_d[0] = 32'hC;
    load_burst(4'd0, 4'd0, "wrap0");
    exp_d[0] = 32'hB;
    load_burst(4'd15, 4'd0, "wrap15");

    // Byte enables
    wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
    store_burst(4'd5, 4'd0);
    wdat[0] = 32'h1234_5678; wbe[0] = 4'b0101;
    store_burst(4'd5, 4'd0);
    exp_d[0] = 32'hFF34_FF78;
    load_burst(4'd5, 4'd0, "be");

    // Stall, blocking and a held request
    req_valid = 1'b1; req_store = 1'b1; req_addr = 4'd12; req_count = 4'd1;
    step();
    req_valid = 1'b0; req_store = 1'b0;
    wr_valid = 1'b1; wr_data = 32'h55; wr_be = 4'hF;
    step();
    wr_valid = 1'b0; wr_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_store = 1'b0; req_addr = 4'd12; req_count = 4'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_wr_ready", 32'(wr_ready), 32'd1);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rd_valid", 32'(rd_valid), 32'd0);
    end
    wr_valid = 1'b1; wr_data = 32'h66;
    step();
    wr_valid = 1'b0;
    check("held_req_ready", 32'(req_ready), 32'd1);
    $display("[TB] stalled store addr=12 beats=2");
    step();
    req_valid = 1'b0;
    exp_d[0] = 32'h55; exp_d[1] = 32'h66; exp_d[2] = 32'hA;
    collect(4'd2, "held");

    // wr_valid in IDLE must not write
    wr_valid = 1'b1; wr_data = 32'hBAD0_BAD0; wr_be = 4'hF;
    step(); step();
    wr_valid = 1'b0;
    exp_d[0] = 32'h55;
    load_burst(4'd12, 4'd0, "idle_wr");

    // Reset mid-load drops rd_valid at once
    for (int i = 0; i < 4; i++) wdat[i] = 32'h90 + i;
    store_burst(4'd8, 4'd3);
    req_valid = 1'b1; req_store = 1'b0; req_addr = 4'd8; req_count = 4'd3;
    step();
    req_valid = 1'b0;
    step(); step();
    check("ml_beat1", rd_data, 32'h91);
    rst = 1'b0;
    #1;
    check_idle_reset("ml_rst");
    step();
    rst = 1'b1;
    step();

    // Reset mid-store after 2 of 4 beats
    req_valid = 1'b1; req_store = 1'b1; req_addr = 4'd8; req_count = 4'd3;
    step();
    req_valid = 1'b0; req_store = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = 32'(i + 1); wr_be = 4'hF;
      step();
    end
    wr_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_reset("ms_rst");
    step();
    rst = 1'b1;
    step();
    exp_d[0] = 32'h1; exp_d[1] = 32'h2; exp_d[2] = 32'h92;
    load_burst(4'd8, 4'd2, "ms");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
